// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive frame controller.
package uart_rx_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int PRESC_8    = 8;
  localparam int PRESC_16   = 16;
  localparam int PRESC_32   = 32;
  localparam int SP_OFFSET  = 3;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_DONE   = 3'd5
  } rx_state_e;

  function automatic logic in_frame(input rx_state_e s);
    return (s == S_START) || (s == S_DATA) || (s == S_PARITY) || (s == S_STOP);
  endfunction

endpackage

// File: rtl/uart_rx_ctrl_edge_bit_counter.sv
// Oversample edge counter and bit counter; both clear whenever enable is low.
module edge_bit_counter #(
  parameter int PRESC_W = 6
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               enable,
  input  logic [PRESC_W-1:0] presc_q,
  output logic [PRESC_W-1:0] edge_cnt,
  output logic [3:0]         bit_cnt,
  output logic               eob
);

  logic [PRESC_W-1:0] presc_m1;

  // An illegal presc_q of 0 wraps to all-ones, so a bit never exceeds 2^PRESC_W cycles.
  assign presc_m1 = presc_q - PRESC_W'(1);
  assign eob      = (edge_cnt == presc_m1);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (!enable) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (eob) begin
      edge_cnt <= '0;
      bit_cnt  <= bit_cnt + 4'd1;
    end else begin
      edge_cnt <= edge_cnt + PRESC_W'(1);
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive frame sequencer: drives sampler/deserializer/checker strobes, issues data_valid.
// Optional UART_RX_ERR_CNT_EN adds a saturating dropped-frame counter output err_cnt.
//
//   state  | meaning
//   IDLE   | line idle, waiting for a low sample
//   START  | start bit, start checker strobed
//   DATA   | DATA_W data bits, deserializer strobed per bit
//   PARITY | parity bit (only when latched PAR_EN)
//   STOP   | stop bit, stop checker strobed
//   DONE   | one cycle, data_valid if frame good
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int PRESC_W = 6
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               RX_IN,
  input  logic               PAR_EN,
  input  logic [PRESC_W-1:0] prescale,
  input  logic               strt_glitch,
  input  logic               par_err,
  input  logic               stp_err,
  output logic [PRESC_W-1:0] edge_cnt,
  output logic [3:0]         bit_cnt,
  output logic               dat_samp_en,
  output logic               deser_en,
  output logic               strt_chk_en,
  output logic               par_chk_en,
  output logic               stp_chk_en,
  output logic               data_valid,
  output logic               busy
`ifdef UART_RX_ERR_CNT_EN
  ,
  output logic [7:0]         err_cnt
`endif
);

  localparam logic [3:0] LAST_DATA = 4'(DATA_W);

  rx_state_e          state, state_nxt;
  logic [PRESC_W-1:0] presc_q;
  logic               par_en_q, par_err_q, stp_err_q, stp_err_d;
  logic               frame_start, cnt_en, eob, pre_sp;
  logic [PRESC_W-1:0] sp_m1;

  // Counters run only while staying inside a frame, so they read 0 on entry and in DONE.
  assign cnt_en = in_frame(state) && in_frame(state_nxt);

  edge_bit_counter #(.PRESC_W(PRESC_W)) u_cnt (
    .CLK      (CLK),
    .RST      (RST),
    .enable   (cnt_en),
    .presc_q  (presc_q),
    .edge_cnt (edge_cnt),
    .bit_cnt  (bit_cnt),
    .eob      (eob)
  );

  // Strobes are registered, so decode the cycle before the strobe point.
  assign sp_m1     = (presc_q >> 1) + PRESC_W'(SP_OFFSET - 1);
  assign pre_sp    = (edge_cnt == sp_m1) && !eob;
  assign stp_err_d = (state == S_STOP && eob) ? stp_err : stp_err_q;

  always_comb begin
    state_nxt   = state;
    frame_start = 1'b0;
    case (state)
      S_IDLE: begin
        if (!RX_IN) begin
          state_nxt   = S_START;
          frame_start = 1'b1;
        end
      end
      S_START:  if (eob) state_nxt = strt_glitch ? S_IDLE : S_DATA;
      S_DATA:   if (eob && bit_cnt == LAST_DATA) state_nxt = par_en_q ? S_PARITY : S_STOP;
      S_PARITY: if (eob) state_nxt = S_STOP;
      S_STOP:   if (eob) state_nxt = S_DONE;
      S_DONE: begin
        if (!RX_IN) begin
          state_nxt   = S_START;
          frame_start = 1'b1;
        end else begin
          state_nxt   = S_IDLE;
        end
      end
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state       <= S_IDLE;
      presc_q     <= '0;
      par_en_q    <= 1'b0;
      par_err_q   <= 1'b0;
      stp_err_q   <= 1'b0;
      dat_samp_en <= 1'b0;
      deser_en    <= 1'b0;
      strt_chk_en <= 1'b0;
      par_chk_en  <= 1'b0;
      stp_chk_en  <= 1'b0;
      data_valid  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      stp_err_q   <= stp_err_d;
      if (state == S_PARITY && eob) par_err_q <= par_err;
      if (frame_start) begin
        presc_q   <= prescale;
        par_en_q  <= PAR_EN;
        par_err_q <= 1'b0;
        stp_err_q <= 1'b0;
      end
      strt_chk_en <= (state == S_START)  && pre_sp;
      deser_en    <= (state == S_DATA)   && pre_sp;
      par_chk_en  <= (state == S_PARITY) && pre_sp;
      stp_chk_en  <= (state == S_STOP)   && pre_sp;
      data_valid  <= (state_nxt == S_DONE) && !par_err_q && !stp_err_d;
      dat_samp_en <= in_frame(state_nxt);
      busy        <= (state_nxt != S_IDLE);
    end
  end

`ifdef UART_RX_ERR_CNT_EN
  logic drop_evt;

  assign drop_evt = (state == S_START && eob && strt_glitch) ||
                    (state_nxt == S_DONE && (par_err_q || stp_err_d));

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      err_cnt <= 8'd0;
    end else if (drop_evt && err_cnt != 8'hFF) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: directed scenarios plus randomized frames vs a frame-level model.
module tb_uart_rx_ctrl;

  localparam int DATA_W  = 8;
  localparam int PRESC_W = 6;

  logic               CLK = 1'b0;
  logic               RST = 1'b0;
  logic               RX_IN = 1'b1;
  logic               PAR_EN = 1'b0;
  logic [PRESC_W-1:0] prescale = PRESC_W'(8);
  logic               strt_glitch = 1'b0;
  logic               par_err = 1'b0;
  logic               stp_err = 1'b0;
  logic [PRESC_W-1:0] edge_cnt;
  logic [3:0]         bit_cnt;
  logic               dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en;
  logic               data_valid, busy;
`ifdef UART_RX_ERR_CNT_EN
  logic [7:0]         err_cnt;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int exp_err  = 0;

  always #5 CLK = ~CLK;

  uart_rx_ctrl #(.DATA_W(DATA_W), .PRESC_W(PRESC_W)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .RX_IN       (RX_IN),
    .PAR_EN      (PAR_EN),
    .prescale    (prescale),
    .strt_glitch (strt_glitch),
    .par_err     (par_err),
    .stp_err     (stp_err),
    .edge_cnt    (edge_cnt),
    .bit_cnt     (bit_cnt),
    .dat_samp_en (dat_samp_en),
    .deser_en    (deser_en),
    .strt_chk_en (strt_chk_en),
    .par_chk_en  (par_chk_en),
    .stp_chk_en  (stp_chk_en),
    .data_valid  (data_valid),
    .busy        (busy)
`ifdef UART_RX_ERR_CNT_EN
    ,
    .err_cnt     (err_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Serial line level for bit index b of a frame (start, LSB-first data, even parity, stop).
  function automatic logic line_bit(input int b, input logic [7:0] d, input bit par);
    if (b == 0) return 1'b0;
    if (b <= DATA_W) return d[b-1];
    if (par && b == DATA_W + 1) return ^d;
    return 1'b1;
  endfunction

  // Entered at a negedge with the DUT in IDLE or DONE; returns at a negedge.
  task automatic run_frame(input int presc, input bit par, input logic [7:0] d,
                           input bit glitch, input bit perr, input bit serr,
                           input bit keep_low, input bit rst_mid, input int new_presc);
    int bits, len, sp;
    int n_strt, n_deser, n_par, n_stp, n_dv, dv_at, bad_pos;
    bit drop, aborted;
    bits    = DATA_W + 2 + (par ? 1 : 0);
    len     = glitch ? presc : bits * presc + 1;
    sp      = presc / 2 + 3;
    drop    = glitch || (par && perr) || serr;
    n_strt  = 0; n_deser = 0; n_par = 0; n_stp = 0; n_dv = 0; dv_at = 0; bad_pos = 0;
    aborted = 1'b0;
    RX_IN       = 1'b0;
    prescale    = PRESC_W'(presc);
    PAR_EN      = par;
    strt_glitch = glitch;
    par_err     = perr;
    stp_err     = serr;
    for (int i = 1; i <= len; i++) begin
      @(negedge CLK);
      if (i == 1) begin
        chk("start_cycle", 32'({busy, dat_samp_en, edge_cnt, bit_cnt}),
            32'({1'b1, 1'b1, {PRESC_W{1'b0}}, 4'd0}));
`ifdef UART_RX_ERR_CNT_EN
        chk("err_cnt_at_start", 32'(err_cnt), exp_err);
`endif
      end
      if (!glitch && i == presc + 1) chk("first_data_bit", 32'(bit_cnt), 1);
      if (strt_chk_en) begin
        n_strt++;
        if (32'(edge_cnt) != sp || bit_cnt != 4'd0) bad_pos++;
      end
      if (deser_en) begin
        n_deser++;
        if (32'(edge_cnt) != sp || 32'(bit_cnt) != n_deser) bad_pos++;
      end
      if (par_chk_en) begin
        n_par++;
        if (32'(edge_cnt) != sp || 32'(bit_cnt) != DATA_W + 1) bad_pos++;
      end
      if (stp_chk_en) begin
        n_stp++;
        if (32'(edge_cnt) != sp || 32'(bit_cnt) != bits - 1) bad_pos++;
      end
      if (data_valid) begin
        n_dv++;
        dv_at = i;
      end
      if (rst_mid && i == 4 * presc + 1) begin
        chk("pre_reset_bit", 32'(bit_cnt), 4);
        RST = 1'b0;
        #1;
        chk("reset_outputs", 32'({edge_cnt, bit_cnt, dat_samp_en, deser_en, strt_chk_en,
                                 par_chk_en, stp_chk_en, data_valid, busy}), 0);
        RX_IN = 1'b1;
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        chk("idle_after_reset", 32'({busy, edge_cnt, bit_cnt}), 0);
        exp_err = 0;
        aborted = 1'b1;
        break;
      end
      if (new_presc != 0 && i == 3 * presc) prescale = PRESC_W'(new_presc);
      if (i < len) RX_IN = glitch ? (i / presc == 0 ? 1'b0 : 1'b1) : line_bit(i / presc, d, par);
      else         RX_IN = 1'b1;
    end
    if (!aborted) begin
      chk("strt_chk_count", n_strt, 1);
      chk("deser_count", n_deser, glitch ? 0 : DATA_W);
      chk("par_chk_count", n_par, (par && !glitch) ? 1 : 0);
      chk("stp_chk_count", n_stp, glitch ? 0 : 1);
      chk("strobe_position", bad_pos, 0);
      chk("data_valid_count", n_dv, drop ? 0 : 1);
      if (!drop) chk("data_valid_latency", dv_at, len);
      if (!glitch) chk("done_cycle", 32'({busy, dat_samp_en}), 32'(2'b10));
      if (drop && exp_err < 255) exp_err++;
      if (!keep_low) begin
        @(negedge CLK);
        chk("back_to_idle", 32'({busy, edge_cnt, bit_cnt}), 0);
`ifdef UART_RX_ERR_CNT_EN
        chk("err_cnt_after", 32'(err_cnt), exp_err);
`endif
      end
    end
  endtask

  task automatic run_illegal(input int presc);
    int  n;
    bit  ended;
    RX_IN       = 1'b0;
    prescale    = PRESC_W'(presc);
    PAR_EN      = 1'($urandom_range(0, 1));
    strt_glitch = 1'b0;
    par_err     = 1'b0;
    stp_err     = 1'b0;
    @(negedge CLK);
    RX_IN = 1'b1;
    n     = 1;
    ended = 1'b0;
    while (n < (DATA_W + 3) * 64 && !ended) begin
      @(negedge CLK);
      n++;
      if (!dat_samp_en) ended = 1'b1;
    end
    chk("illegal_presc_ends", 32'(ended), 1);
    for (int j = 0; j < 4 && busy; j++) @(negedge CLK);
    chk("illegal_presc_idle", 32'(busy), 0);
  endtask

  initial begin
    repeat (3) @(negedge CLK);
    chk("reset_state", 32'({edge_cnt, bit_cnt, dat_samp_en, deser_en, strt_chk_en,
                           par_chk_en, stp_chk_en, data_valid, busy}), 0);
`ifdef UART_RX_ERR_CNT_EN
    chk("reset_err_cnt", 32'(err_cnt), 0);
`endif
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    chk("idle_after_release", 32'(busy), 0);

    run_frame(8, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    run_frame(16, 1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    run_frame(8, 1'b0, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    run_frame(32, 1'b1, 8'($urandom), 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0);
    run_frame(32, 1'b1, 8'($urandom), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    run_frame(8, 1'b0, 8'($urandom), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    run_frame(8, 1'b0, 8'($urandom), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    run_frame(8, 1'b0, 8'($urandom), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16);
    run_frame(16, 1'b0, 8'($urandom), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);

    for (int k = 0; k < 14; k++) begin
      int p;
      bit pe, g, pr, sr, kl;
      case ($urandom_range(0, 2))
        0:       p = 8;
        1:       p = 16;
        default: p = 32;
      endcase
      pe = 1'($urandom_range(0, 1));
      g  = ($urandom_range(0, 7) == 0);
      pr = ($urandom_range(0, 3) == 0);
      sr = ($urandom_range(0, 3) == 0);
      kl = !g && (k < 13) && ($urandom_range(0, 1) == 1);
      run_frame(p, pe, 8'($urandom), g, pr, sr, kl, 1'b0, 0);
    end

    for (int k = 0; k < 2; k++) begin
      int p;
      do p = $urandom_range(1, 63); while (p == 8 || p == 16 || p == 32);
      run_illegal(p);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
